// File: rtl/iir_pkg.sv
// Shared types and helpers for the time-multiplexed biquad engine.
// Widths are passed in so the helpers follow the top-level parameters.
package iir_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      STORE
   } state_t;

   localparam int NUM_TAPS = 5;

   function automatic int acc_width(input int dw, input int cw, input int guard);
      return dw + cw + guard;
   endfunction

   // Clamp to a signed dw-bit range; caller truncates to dw bits.
   function automatic logic signed [63:0] saturate(
      input logic signed [63:0] v,
      input int dw
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/iir_mac.sv
// Single shared multiplier with a registered add/subtract accumulator.
// clr wins over en so a new channel always starts from zero.
module iir_mac
   import iir_pkg::*;
#(
   parameter int CW = 18,
   parameter int DW = 16,
   parameter int AW = 37
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 sub,
   input  logic signed [CW-1:0] a,
   input  logic signed [DW-1:0] b,
   output logic signed [AW-1:0] acc
);

   logic signed [CW+DW-1:0] prod;
   logic signed [AW-1:0]    term;

   assign prod = a * b;
   assign term = AW'(prod);

   always_ff @(posedge clk) begin
      if (clr)
         acc <= '0;
      else if (en)
         acc <= sub ? acc - term : acc + term;
   end

endmodule

// File: rtl/iir_biquad_scheduler.sv
// Stereo direct-form-I biquad sharing one MAC across both channels.
// Inputs and coefficients are shadowed on the accepted tick.
module iir_biquad_scheduler
   import iir_pkg::*;
#(
   parameter int COEFF_WIDTH = 18,
   parameter int COEFF_SCALE = 14,
   parameter int DATA_WIDTH  = 16,
   parameter int ACC_GUARD   = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sample_tick,
   input  logic signed [DATA_WIDTH-1:0]  in_l,
   input  logic signed [DATA_WIDTH-1:0]  in_r,
   input  logic signed [COEFF_WIDTH-1:0] A2,
   input  logic signed [COEFF_WIDTH-1:0] A3,
   input  logic signed [COEFF_WIDTH-1:0] B1,
   input  logic signed [COEFF_WIDTH-1:0] B2,
   input  logic signed [COEFF_WIDTH-1:0] B3,
   output logic signed [DATA_WIDTH-1:0]  out_l,
   output logic signed [DATA_WIDTH-1:0]  out_r,
   output logic                          out_valid,
   output logic                          busy,
   output logic                          overrun
);

   localparam int AW = acc_width(DATA_WIDTH, COEFF_WIDTH, ACC_GUARD);

   typedef logic signed [DATA_WIDTH-1:0]  data_t;
   typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

   state_t     state;
   logic       ch;
   logic [2:0] step;

   data_t  xin [2];
   data_t  x1  [2];
   data_t  x2  [2];
   data_t  y1  [2];
   data_t  y2  [2];
   coeff_t a2_s, a3_s, b1_s, b2_s, b3_s;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_sh;
   data_t                y_new;

   coeff_t mac_a;
   data_t  mac_b;
   logic   mac_sub;
   logic   mac_en;
   logic   mac_clr;

   always_comb begin
      mac_a   = b1_s;
      mac_b   = xin[ch];
      mac_sub = 1'b0;
      case (step)
         3'd1: begin
            mac_a = b2_s;
            mac_b = x1[ch];
         end
         3'd2: begin
            mac_a = b3_s;
            mac_b = x2[ch];
         end
         3'd3: begin
            mac_a   = a2_s;
            mac_b   = y1[ch];
            mac_sub = 1'b1;
         end
         3'd4: begin
            mac_a   = a3_s;
            mac_b   = y2[ch];
            mac_sub = 1'b1;
         end
         default: ;
      endcase
   end

   assign mac_en  = (state == MAC);
   assign mac_clr = reset
                  | ((state == IDLE) & sample_tick)
                  | (state == STORE);

   iir_mac #(
      .CW (COEFF_WIDTH),
      .DW (DATA_WIDTH),
      .AW (AW)
   ) u_mac (
      .clk (clk),
      .clr (mac_clr),
      .en  (mac_en),
      .sub (mac_sub),
      .a   (mac_a),
      .b   (mac_b),
      .acc (acc)
   );

   assign acc_sh = acc >>> COEFF_SCALE;
   assign y_new  = DATA_WIDTH'(saturate(64'(acc_sh), DATA_WIDTH));
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ch        <= 1'b0;
         step      <= '0;
         xin       <= '{default: '0};
         x1        <= '{default: '0};
         x2        <= '{default: '0};
         y1        <= '{default: '0};
         y2        <= '{default: '0};
         a2_s      <= '0;
         a3_s      <= '0;
         b1_s      <= '0;
         b2_s      <= '0;
         b3_s      <= '0;
         out_l     <= '0;
         out_r     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         overrun   <= sample_tick & (state != IDLE);
         case (state)
            IDLE: begin
               if (sample_tick) begin
                  xin[0] <= in_l;
                  xin[1] <= in_r;
                  a2_s   <= A2;
                  a3_s   <= A3;
                  b1_s   <= B1;
                  b2_s   <= B2;
                  b3_s   <= B3;
                  ch     <= 1'b0;
                  step   <= '0;
                  state  <= MAC;
               end
            end
            MAC: begin
               if (step == 3'(NUM_TAPS - 1))
                  state <= STORE;
               else
                  step <= step + 3'd1;
            end
            STORE: begin
               x2[ch] <= x1[ch];
               x1[ch] <= xin[ch];
               y2[ch] <= y1[ch];
               y1[ch] <= y_new;
               if (!ch) begin
                  ch    <= 1'b1;
                  step  <= '0;
                  state <= MAC;
               end else begin
                  // left result was committed to y1[0] one pass earlier
                  out_l     <= y1[0];
                  out_r     <= y_new;
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Self-checking bench for iir_biquad_scheduler.
// A behavioural model fills a scoreboard at every accepted tick.
module tb_iir_biquad_scheduler;

   localparam int CS = 14;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sample_tick = 1'b0;
   logic signed [15:0] in_l = '0;
   logic signed [15:0] in_r = '0;
   logic signed [17:0] A2 = '0;
   logic signed [17:0] A3 = '0;
   logic signed [17:0] B1 = '0;
   logic signed [17:0] B2 = '0;
   logic signed [17:0] B3 = '0;
   logic signed [15:0] out_l;
   logic signed [15:0] out_r;
   logic out_valid;
   logic busy;
   logic overrun;

   int checks = 0;
   int failures = 0;
   int exp_l[$];
   int exp_r[$];
   longint mx1[2];
   longint mx2[2];
   longint my1[2];
   longint my2[2];

   always #5 clk = ~clk;

   iir_biquad_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick),
      .in_l        (in_l),
      .in_r        (in_r),
      .A2          (A2),
      .A3          (A3),
      .B1          (B1),
      .B2          (B2),
      .B3          (B3),
      .out_l       (out_l),
      .out_r       (out_r),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   function automatic void model_clear();
      for (int c = 0; c < 2; c++) begin
         mx1[c] = 0;
         mx2[c] = 0;
         my1[c] = 0;
         my2[c] = 0;
      end
      exp_l.delete();
      exp_r.delete();
   endfunction

   function automatic longint model_ch(input int c, input longint x);
      longint acc;
      longint y;
      acc = longint'(B1) * x + longint'(B2) * mx1[c] + longint'(B3) * mx2[c]
          - longint'(A2) * my1[c] - longint'(A3) * my2[c];
      y = acc >>> CS;
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      mx2[c] = mx1[c];
      mx1[c] = x;
      my2[c] = my1[c];
      my1[c] = y;
      return y;
   endfunction

   function automatic void model_push();
      exp_l.push_back(int'(model_ch(0, longint'(in_l))));
      exp_r.push_back(int'(model_ch(1, longint'(in_r))));
   endfunction

   task automatic set_coef(input int b1, input int b2, input int b3,
                           input int a2, input int a3);
      B1 = 18'(b1);
      B2 = 18'(b2);
      B3 = 18'(b3);
      A2 = 18'(a2);
      A3 = 18'(a3);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      sample_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   // Leaves the caller observing the state right after the accepting edge.
   task automatic pulse_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      model_push();
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic wait_valid(input int max, output bit got);
      got = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sample_tick = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_overrun got=%b exp=0", overrun);
      end
      checks++;
      if (out_l !== 16'sd0 || out_r !== 16'sd0) begin
         failures++;
         $display("FAIL reset_out got=%0d/%0d exp=0/0", out_l, out_r);
      end
      sample_tick = 1'b0;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_passthrough();
      int bad;
      int el;
      int er;
      do_reset();
      set_coef(16384, 0, 0, 0, 0);
      in_l = 16'sd1000;
      in_r = -16'sd1000;
      pulse_tick();
      bad = (busy !== 1'b1) ? 1 : 0;
      for (int i = 1; i < 12; i++) begin
         @(negedge clk);
         if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL pass_busy_window got=%0d bad cycles exp=0", bad);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL pass_valid_edge12 got=%b exp=1", out_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL pass_busy_edge12 got=%b exp=0", busy);
      end
      el = exp_l.pop_front();
      er = exp_r.pop_front();
      checks++;
      if (int'(out_l) != el || int'(out_r) != er) begin
         failures++;
         $display("FAIL pass_model got=%0d/%0d exp=%0d/%0d", out_l, out_r, el, er);
      end
      checks++;
      if (out_l !== 16'sd1000 || out_r !== -16'sd1000) begin
         failures++;
         $display("FAIL pass_value got=%0d/%0d exp=1000/-1000", out_l, out_r);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_l !== 16'sd1000) begin
         failures++;
         $display("FAIL pass_hold got=%b/%0d exp=0/1000", out_valid, out_l);
      end
   endtask

   task automatic test_lowpass();
      int el;
      int er;
      int bad;
      int d;
      bit got;
      do_reset();
      set_coef(1183, 2367, 1183, -18174, 6523);
      in_l = 16'sd10000;
      in_r = 16'sd10000;
      bad = 0;
      for (int n = 0; n < 60; n++) begin
         pulse_tick();
         got = 1'b0;
         for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
               got = 1'b1;
               el = exp_l.size() > 0 ? exp_l.pop_front() : 99999;
               er = exp_r.size() > 0 ? exp_r.pop_front() : 99999;
               if (int'(out_l) != el || int'(out_r) != er) bad++;
               checks++;
               if (out_l !== out_r) begin
                  failures++;
                  $display("FAIL lp_lr_equal n=%0d got=%0d/%0d", n, out_l, out_r);
               end
               if (n == 0) begin
                  checks++;
                  if (out_l !== 16'sd722 || out_r !== 16'sd722) begin
                     failures++;
                     $display("FAIL lp_first got=%0d/%0d exp=722", out_l, out_r);
                  end
               end
            end
         end
         checks++;
         if (!got) begin
            failures++;
            $display("FAIL lp_timeout n=%0d got=no out_valid exp=out_valid", n);
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL lp_model got=%0d mismatching samples exp=0", bad);
      end
      d = int'(out_l) - 10000;
      checks++;
      if (d > 3 || d < -3) begin
         failures++;
         $display("FAIL lp_settle got=%0d exp=10000+-3", out_l);
      end
   endtask

   task automatic test_saturation();
      bit got;
      int el;
      int er;
      do_reset();
      set_coef(32768, 0, 0, 0, 0);
      in_l = 16'sd30000;
      in_r = -16'sd30000;
      pulse_tick();
      wait_valid(20, got);
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL sat_timeout got=no out_valid exp=out_valid");
      end
      el = exp_l.pop_front();
      er = exp_r.pop_front();
      checks++;
      if (out_l !== 16'sd32767 || int'(out_l) != el) begin
         failures++;
         $display("FAIL sat_pos got=%0d exp=32767", out_l);
      end
      checks++;
      if (out_r !== -16'sd32768 || int'(out_r) != er) begin
         failures++;
         $display("FAIL sat_neg got=%0d exp=-32768", out_r);
      end
   endtask

   task automatic test_overrun();
      int ovbad;
      int nval;
      int v1;
      int v2;
      int bad;
      int j;
      int el;
      int er;
      do_reset();
      set_coef(16384, 0, 0, 0, 0);
      in_l = 16'sd500;
      in_r = -16'sd500;
      ovbad = 0;
      nval = 0;
      v1 = -1;
      v2 = -1;
      bad = 0;
      for (int k = 0; k < 28; k++) begin
         @(negedge clk);
         if (k > 0) begin
            j = k - 1;
            if (overrun !== ((j == 5 || j == 12) ? 1'b1 : 1'b0)) ovbad++;
            if (j == 13 && busy !== 1'b1) bad++;
            if (out_valid === 1'b1) begin
               nval++;
               if (v1 < 0) v1 = j;
               else v2 = j;
               el = exp_l.size() > 0 ? exp_l.pop_front() : 99999;
               er = exp_r.size() > 0 ? exp_r.pop_front() : 99999;
               if (int'(out_l) != el || int'(out_r) != er) bad++;
            end
         end
         if (k == 1) begin
            in_l = 16'sd1111;
            in_r = -16'sd1111;
         end
         if (k == 13) begin
            in_l = 16'sd700;
            in_r = -16'sd700;
         end
         sample_tick = (k == 0 || k == 5 || k == 12 || k == 13);
         if (k == 0 || k == 13) model_push();
      end
      sample_tick = 1'b0;
      checks++;
      if (ovbad != 0) begin
         failures++;
         $display("FAIL ovr_pulses got=%0d wrong cycles exp=0", ovbad);
      end
      checks++;
      if (nval != 2) begin
         failures++;
         $display("FAIL ovr_valid_count got=%0d exp=2", nval);
      end
      checks++;
      if (v1 != 12 || v2 != 25) begin
         failures++;
         $display("FAIL ovr_valid_edges got=%0d/%0d exp=12/25", v1, v2);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL ovr_data got=%0d bad exp=0", bad);
      end
   endtask

   task automatic test_shadow();
      bit got;
      int el;
      int er;
      do_reset();
      set_coef(16384, 0, 0, 0, 0);
      in_l = 16'sd2000;
      in_r = -16'sd3000;
      pulse_tick();
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 2) begin
            B1 = 18'sd0;
            in_l = 16'sd5;
            in_r = 16'sd6;
         end
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL shadow_valid got=%b exp=1", out_valid);
      end
      el = exp_l.pop_front();
      er = exp_r.pop_front();
      checks++;
      if (out_l !== 16'sd2000 || out_r !== -16'sd3000 || int'(out_l) != el || int'(out_r) != er) begin
         failures++;
         $display("FAIL shadow_first got=%0d/%0d exp=2000/-3000", out_l, out_r);
      end
      pulse_tick();
      wait_valid(20, got);
      el = exp_l.pop_front();
      er = exp_r.pop_front();
      checks++;
      if (!got || out_l !== 16'sd0 || out_r !== 16'sd0 || int'(out_l) != el || int'(out_r) != er) begin
         failures++;
         $display("FAIL shadow_second got=%0d/%0d valid=%b exp=0/0", out_l, out_r, got);
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      int nval;
      int el;
      int er;
      do_reset();
      // b2 = 0.5 makes the result depend on the previous input
      set_coef(16384, 8192, 0, 0, 0);
      in_l = 16'sd4000;
      in_r = -16'sd4000;
      pulse_tick();
      wait_valid(20, got);
      checks++;
      if (!got || out_l !== 16'sd4000) begin
         failures++;
         $display("FAIL rmid_pre got=%0d exp=4000", out_l);
      end
      pulse_tick();
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmid_state got=busy %b valid %b exp=0/0", busy, out_valid);
      end
      checks++;
      if (out_l !== 16'sd0 || out_r !== 16'sd0) begin
         failures++;
         $display("FAIL rmid_out got=%0d/%0d exp=0/0", out_l, out_r);
      end
      nval = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) nval++;
      end
      checks++;
      if (nval != 0) begin
         failures++;
         $display("FAIL rmid_no_valid got=%0d exp=0", nval);
      end
      in_l = 16'sd1500;
      in_r = -16'sd2500;
      pulse_tick();
      wait_valid(20, got);
      el = exp_l.pop_front();
      er = exp_r.pop_front();
      checks++;
      if (!got || out_l !== 16'sd1500 || out_r !== -16'sd2500 || int'(out_l) != el || int'(out_r) != er) begin
         failures++;
         $display("FAIL rmid_after got=%0d/%0d exp=1500/-2500", out_l, out_r);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      int ovr;
      int el;
      int er;
      do_reset();
      set_coef(int'($urandom_range(0, 16384)) - 8192,
               int'($urandom_range(0, 16384)) - 8192,
               int'($urandom_range(0, 16384)) - 8192,
               int'($urandom_range(0, 8192)) - 4096,
               int'($urandom_range(0, 8192)) - 4096);
      bad = 0;
      ovr = 0;
      for (int n = 0; n < 6; n++) begin
         in_l = 16'($urandom);
         in_r = 16'($urandom);
         pulse_tick();
         for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (overrun === 1'b1) ovr++;
         end
         if (out_valid !== 1'b1) begin
            bad++;
         end else begin
            el = exp_l.size() > 0 ? exp_l.pop_front() : 99999;
            er = exp_r.size() > 0 ? exp_r.pop_front() : 99999;
            if (int'(out_l) != el || int'(out_r) != er) bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL b2b_data got=%0d bad samples exp=0", bad);
      end
      checks++;
      if (ovr != 0) begin
         failures++;
         $display("FAIL b2b_overrun got=%0d pulses exp=0", ovr);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lowpass();
      test_saturation();
      test_overrun();
      test_shadow();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
